// File: rtl/prince_ti_sbox_layer_pkg.sv
// prince_ti_pkg: shared constants for the masked PRINCE S-box layer.
//   SBOX / SBOX_INV  : unmasked reference tables, index = nibble, packed with
//                      entry 0 in the least significant nibble.
//   SHARE_TUPLE      : share selection per TI component. Bit 3..0 = x,y,z,w;
//                      a 0 bit reads share 0, a 1 bit reads share 1.
//   ANF_S / ANF_SINV : ANF coefficients per output bit. Monomial index u uses
//                      bit 3..0 = x,y,z,w.
//   OWNER            : OWNER[j][u] = 1 when component j is the one that
//                      evaluates the share-expansion term of monomial u that
//                      matches its tuple.
package prince_ti_pkg;

   localparam int NIBBLE_W = 4;
   localparam int NUM_COMP = 8;

   localparam logic [15:0][3:0] SBOX     = 64'h4D5E_0876_19CA_23FB;
   localparam logic [15:0][3:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

   // Component order: 1111, 1122, 1212, 1221, 2112, 2121, 2211, 2222 (index 0..7).
   // The set is the even-weight half of {1,2}^4. Any three of its columns
   // contain all eight share combinations, so every term of a degree-3
   // monomial lands in exactly one component.
   localparam logic [NUM_COMP-1:0][3:0] SHARE_TUPLE = {
      4'b1111, 4'b1100, 4'b1010, 4'b1001,
      4'b0110, 4'b0101, 4'b0011, 4'b0000
   };

   // Moebius transform of each output bit. Both tables are permutations, so
   // every output bit is balanced. The xyzw coefficient is therefore 0, and
   // the 8 components cover the whole ANF.
   function automatic logic [3:0][15:0] anf_of(input logic [15:0][3:0] tbl);
      logic [3:0][15:0] r;
      r = '0;
      for (int b = 0; b < 4; b++)
         for (int u = 0; u < 16; u++)
            for (int x = 0; x < 16; x++)
               if ((4'(x) & ~4'(u)) == 4'b0000)
                  r[2'(b)][4'(u)] = r[2'(b)][4'(u)] ^ tbl[4'(x)][2'(b)];
      return r;
   endfunction

   // For each monomial, the lowest-index component whose tuple matches on the
   // monomial's variables evaluates that term. This gives exactly one owner
   // per term. The constant term (u = 0) goes to component 1111.
   function automatic logic [NUM_COMP-1:0][15:0] owner_map();
      logic [NUM_COMP-1:0][15:0] r;
      int k;
      r = '0;
      for (int j = 0; j < NUM_COMP; j++)
         for (int u = 0; u < 16; u++) begin
            k = j;
            for (int c = NUM_COMP - 1; c >= 0; c--)
               if ((SHARE_TUPLE[3'(c)] & 4'(u)) == (SHARE_TUPLE[3'(j)] & 4'(u)))
                  k = c;
            r[3'(j)][4'(u)] = (k == j);
         end
      return r;
   endfunction

   localparam logic [3:0][15:0]          ANF_S    = anf_of(SBOX);
   localparam logic [3:0][15:0]          ANF_SINV = anf_of(SBOX_INV);
   localparam logic [NUM_COMP-1:0][15:0] OWNER    = owner_map();

endpackage

// File: rtl/prince_ti_sbox_lane.sv
// prince_ti_sbox_lane: combinational TI expansion of one 4-bit lane.
//   inv  : 0 selects the S components, 1 selects the S^-1 components.
//   sh0  : share 0 of the nibble {x,y,z,w}.
//   sh1  : share 1 of the nibble {x,y,z,w}.
//   comp : [bit][component] 8 non-complete components per output bit.
module prince_ti_sbox_lane
   import prince_ti_pkg::*;
(
   input  logic                          inv,
   input  logic [NIBBLE_W-1:0]           sh0,
   input  logic [NIBBLE_W-1:0]           sh1,
   output logic [3:0][NUM_COMP-1:0]      comp
);

   // The XOR of the owned monomials, with each variable taken from the share
   // that the tuple names. The tuple is a constant per instance, so each
   // variable resolves to a single fixed share wire. No share mux is built.
   function automatic logic comp_eval(input logic [15:0] anf,
                                      input logic [15:0] own,
                                      input logic [3:0]  tup,
                                      input logic [3:0]  s0,
                                      input logic [3:0]  s1);
      logic       acc;
      logic       term;
      logic [3:0] um;
      acc = 1'b0;
      for (int u = 0; u < 16; u++) begin
         um = 4'(u);
         if (anf[um] && own[um]) begin
            term = 1'b1;
            for (int v = 0; v < 4; v++)
               if (um[2'(v)])
                  term = term & (tup[2'(v)] ? s1[2'(v)] : s0[2'(v)]);
            acc = acc ^ term;
         end
      end
      return acc;
   endfunction

   logic [3:0][NUM_COMP-1:0] comp_s;
   logic [3:0][NUM_COMP-1:0] comp_i;

   for (genvar b = 0; b < 4; b++) begin : g_bit
      for (genvar j = 0; j < NUM_COMP; j++) begin : g_comp
         assign comp_s[b][j] = comp_eval(ANF_S[b],    OWNER[j], SHARE_TUPLE[j], sh0, sh1);
         assign comp_i[b][j] = comp_eval(ANF_SINV[b], OWNER[j], SHARE_TUPLE[j], sh0, sh1);
      end
   end

   // The select comes after evaluation and pairs components that share the
   // same tuple. inv is public, so the result is still non-complete.
   assign comp = inv ? comp_i : comp_s;

endmodule

// File: rtl/prince_ti_sbox_layer.sv
// prince_ti_sbox_layer: 2-stage first-order TI S-box layer for masked PRINCE.
//   clk, rst                      : clock; asynchronous active-high reset.
//   in_valid_i / in_ready_o       : input handshake; the beat carries inv_i,
//                                   in_share0_i, in_share1_i and rand_i.
//   out_valid_o / out_ready_i     : output handshake for out_share0_o and
//                                   out_share1_o.
//   busy_o                        : at least one pipeline stage is occupied.
// Stage 1 registers the 8 components per output bit. These registers are the
// glitch barrier. Stage 2 compresses the components to 2 shares with
// one fresh bit per output bit.
module prince_ti_sbox_layer
   import prince_ti_pkg::*;
#(
   parameter  int NUM_SBOX = 16,
   localparam int STATE_W  = NIBBLE_W * NUM_SBOX,
   localparam int RAND_W   = NIBBLE_W * NUM_SBOX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               inv_i,
   input  logic [STATE_W-1:0] in_share0_i,
   input  logic [STATE_W-1:0] in_share1_i,
   input  logic [RAND_W-1:0]  rand_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [STATE_W-1:0] out_share0_o,
   output logic [STATE_W-1:0] out_share1_o,
   output logic               busy_o
);

   logic [NUM_SBOX-1:0][3:0][NUM_COMP-1:0] comp;
   logic [NUM_SBOX-1:0][3:0][NUM_COMP-1:0] s1_comp;
   logic [RAND_W-1:0]                      s1_rand;
   logic [2:1]                             vld_pipe;
   logic [STATE_W-1:0]                     c_sh0, c_sh1;
   logic [STATE_W-1:0]                     s2_sh0, s2_sh1;
   logic                                   s1_load, s2_load;

   for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
      prince_ti_sbox_lane u_lane (
         .inv  (inv_i),
         .sh0  (in_share0_i[NIBBLE_W*k +: NIBBLE_W]),
         .sh1  (in_share1_i[NIBBLE_W*k +: NIBBLE_W]),
         .comp (comp[k])
      );
   end

   // Stage 2 advances when it is empty or drained. Stage 1 advances whenever
   // stage 2 takes its beat. This allows accept and emit in the same cycle.
   assign s2_load    = !vld_pipe[2] || out_ready_i;
   assign s1_load    = !vld_pipe[1] || s2_load;
   assign in_ready_o = s1_load;

   // Components 1-4 (index 0..3) go to share 0 and 5-8 go to share 1. The
   // same random bit is added to both shares, so the recombined value is
   // unchanged while each share is refreshed.
   for (genvar k = 0; k < NUM_SBOX; k++) begin : g_cmp_lane
      for (genvar b = 0; b < 4; b++) begin : g_cmp_bit
         assign c_sh0[NIBBLE_W*k + b] = (^s1_comp[k][b][3:0]) ^ s1_rand[NIBBLE_W*k + b];
         assign c_sh1[NIBBLE_W*k + b] = (^s1_comp[k][b][7:4]) ^ s1_rand[NIBBLE_W*k + b];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_comp  <= '0;
         s1_rand  <= '0;
         s2_sh0   <= '0;
         s2_sh1   <= '0;
      end else begin
         if (s1_load) begin
            vld_pipe[1] <= in_valid_i;
            if (in_valid_i) begin
               s1_comp <= comp;
               s1_rand <= rand_i;
            end
         end
         if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               s2_sh0 <= c_sh0;
               s2_sh1 <= c_sh1;
            end
         end
      end
   end

   assign out_valid_o  = vld_pipe[2];
   assign out_share0_o = s2_sh0;
   assign out_share1_o = s2_sh1;
   assign busy_o       = |vld_pipe;

endmodule
